vd_frame_ctrl: RTL and testbench

VD_FRAME_CTRL -- requirements
Module: vd_frame_ctrl

---
 rtl/vd_frame_ctrl.sv | 139 +++++++++++++
 tb/tb_vd_frame_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/vd_frame_ctrl.sv
// Frame controller for a Viterbi decoder: syncs on the first nonzero symbol, forwards frame_len
// data symbols, appends TAIL zero symbols, then drains zeros until frame_len decoded bits are out.
module vd_frame_ctrl #(
  parameter int WD_CODE = 2,
  parameter int LEN_W   = 12,
  parameter int TAIL    = 8,
  parameter int DEC_LAT = 40,
  parameter int SYM_DIV = 4
) (
  input  logic               CLOCK,
  input  logic               Reset,
  input  logic               start,
  input  logic [LEN_W-1:0]   frame_len,
  input  logic               sym_stb,
  input  logic [WD_CODE-1:0] sym_code,
  output logic               dec_active,
  output logic [WD_CODE-1:0] dec_code,
  output logic               dec_stb,
  input  logic               dec_out,
  output logic               bit_out,
  output logic               bit_valid,
  output logic               busy,
  output logic               frame_done,
  output logic               overrun,
  output logic [2:0]         state_dbg
);

  // Strobes carry no backpressure: sym_stb, dec_stb and bit_valid are one-cycle "valid" pulses
  // whose data is taken in that same cycle; the consumer is always ready.

  localparam int CW = LEN_W + 1;
  localparam int DW = $clog2(SYM_DIV);

  typedef enum logic [2:0] {IDLE, SYNC, RUN, FLUSH, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   len_q, stb_idx, bit_cnt, tail_cnt;
  logic [DW-1:0]   div_cnt;
  logic            accept_start, take_data, take_zero, set_ovr;
  logic            bits_left, div_tick, sample, finish;

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge CLOCK) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    accept_start = 1'b0;
    take_data    = 1'b0;
    take_zero    = 1'b0;
    set_ovr      = 1'b0;
    bits_left    = (bit_cnt < len_q);
    // Generated symbols stop as soon as the last bit is counted, so none leaks past frame_done.
    div_tick     = (div_cnt == DW'(SYM_DIV - 1)) && bits_left;
    sample       = dec_stb && (stb_idx > CW'(DEC_LAT)) && bits_left;
    finish       = bit_valid && (bit_cnt == len_q) && (state != IDLE);
    unique case (state)
      IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          state_nxt    = SYNC;
        end
      end
      SYNC: begin
        if (sym_stb && (sym_code != '0)) begin
          take_data = 1'b1;
          state_nxt = (len_q == CW'(1)) ? FLUSH : RUN;
        end
      end
      RUN: begin
        if (sym_stb) begin
          take_data = 1'b1;
          if (stb_idx + CW'(1) == len_q) state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        set_ovr = sym_stb;
        if (div_tick) begin
          take_zero = 1'b1;
          if (tail_cnt == CW'(TAIL - 1)) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        set_ovr   = sym_stb;
        take_zero = div_tick;
      end
      default: state_nxt = IDLE;
    endcase
    if (finish) state_nxt = IDLE;
  end

  always_ff @(posedge CLOCK) begin
    if (!Reset) begin
      len_q      <= '0;
      stb_idx    <= '0;
      bit_cnt    <= '0;
      tail_cnt   <= '0;
      div_cnt    <= '0;
      dec_active <= 1'b0;
      dec_code   <= '0;
      dec_stb    <= 1'b0;
      bit_out    <= 1'b0;
      bit_valid  <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      dec_stb    <= take_data | take_zero;
      bit_valid  <= sample;
      frame_done <= finish;
      if (accept_start) begin
        len_q    <= (frame_len == '0) ? CW'(1) : {1'b0, frame_len};
        stb_idx  <= '0;
        bit_cnt  <= '0;
        tail_cnt <= '0;
      end else begin
        if (take_data | take_zero)        stb_idx  <= stb_idx + CW'(1);
        if (sample)                       bit_cnt  <= bit_cnt + CW'(1);
        if (take_zero && (state == FLUSH)) tail_cnt <= tail_cnt + CW'(1);
      end
      if (take_data)      dec_code <= sym_code;
      else if (take_zero) dec_code <= '0;
      if (sample) bit_out <= dec_out;
      // Spacing counter restarts on entry to FLUSH, so the first tail lands SYM_DIV cycles later.
      if ((state == FLUSH) || (state == DRAIN))
        div_cnt <= (div_cnt == DW'(SYM_DIV - 1)) ? '0 : div_cnt + DW'(1);
      else
        div_cnt <= '0;
      if (frame_done)     dec_active <= 1'b0;
      else if (take_data) dec_active <= 1'b1;
      if (accept_start)   overrun <= 1'b0;
      else if (set_ovr)   overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vd_frame_ctrl.sv
// Directed bench for vd_frame_ctrl: reset, a full frame with an injected overrun, mid-frame
// reset, a two-bit frame and a zero-length frame, all against hand-computed expectations.
module tb_vd_frame_ctrl;

  localparam int WD_CODE = 2;
  localparam int LEN_W   = 12;

  logic               CLOCK = 1'b0;
  logic               Reset = 1'b0;
  logic               start = 1'b0;
  logic [LEN_W-1:0]   frame_len = '0;
  logic               sym_stb = 1'b0;
  logic [WD_CODE-1:0] sym_code = '0;
  logic               dec_active, dec_stb, bit_out, bit_valid, busy, frame_done, overrun;
  logic [WD_CODE-1:0] dec_code;
  logic               dec_out = 1'b0;
  logic [2:0]         state_dbg;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  // Monitor log, cleared at every start and while Reset is low
  int n_stb = 0;
  int fd_cnt = 0;
  int fd_cyc = 0;
  logic fd_busy = 1'b0;
  logic fd_act = 1'b0;
  int stb_cyc[$];
  int stb_code[$];
  int stb_state[$];
  int bv_idx[$];
  int bv_bit[$];
  int bv_cyc[$];

  vd_frame_ctrl #(.WD_CODE(WD_CODE), .LEN_W(LEN_W), .TAIL(8), .DEC_LAT(40), .SYM_DIV(4)) dut (
    .CLOCK(CLOCK), .Reset(Reset), .start(start), .frame_len(frame_len),
    .sym_stb(sym_stb), .sym_code(sym_code), .dec_active(dec_active), .dec_code(dec_code),
    .dec_stb(dec_stb), .dec_out(dec_out), .bit_out(bit_out), .bit_valid(bit_valid),
    .busy(busy), .frame_done(frame_done), .overrun(overrun), .state_dbg(state_dbg)
  );

  // Clock / cycle counter
  always #5 CLOCK = ~CLOCK;
  always @(posedge CLOCK) cyc <= cyc + 1;

  // Decoder stand-in: DecodeOut is the LSB of the dec_stb index within the frame
  always @(negedge CLOCK) begin
    if (start || !Reset) begin
      n_stb = 0; fd_cnt = 0;
      stb_cyc.delete(); stb_code.delete(); stb_state.delete();
      bv_idx.delete(); bv_bit.delete(); bv_cyc.delete();
    end else begin
      if (dec_stb) begin
        n_stb = n_stb + 1;
        stb_cyc.push_back(cyc);
        stb_code.push_back(int'(dec_code));
        stb_state.push_back(int'(state_dbg));
        dec_out = n_stb[0];
      end
      if (bit_valid) begin
        bv_idx.push_back(n_stb);
        bv_bit.push_back(int'(bit_out));
        bv_cyc.push_back(cyc);
      end
      if (frame_done) begin
        fd_cnt = fd_cnt + 1;
        fd_cyc = cyc;
        fd_busy = busy;
        fd_act = dec_active;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic start_frame(input int len);
    start = 1'b1; frame_len = LEN_W'(len);
    tick();
    start = 1'b0;
  endtask

  task automatic send_sym(input logic [WD_CODE-1:0] code);
    sym_stb = 1'b1; sym_code = code;
    tick();
    sym_stb = 1'b0;
    tick();
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (fd_cnt > 0) break;
    end
    check(tag, 32'(fd_cnt), 32'd1);
    repeat (12) tick();
  endtask

  function automatic int zero_tail_bad(input int from);
    int bad = 0;
    for (int i = from; i < stb_code.size(); i++) begin
      if (stb_code[i] != 0) bad++;
      if (stb_cyc[i] - stb_cyc[i-1] != 4) bad++;
    end
    return bad;
  endfunction

  logic [8:0] all_out;
  assign all_out = {dec_active, dec_code, dec_stb, bit_out, bit_valid, busy, frame_done, overrun};

  initial begin
    // Reset held with start and sym_stb active
    Reset = 1'b0; start = 1'b1; sym_stb = 1'b1; sym_code = 2'b11; frame_len = 12'd5;
    tick(); tick();
    check("reset_outputs", 32'(all_out), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_state", 32'(state_dbg), 32'd0);
    start = 1'b0; sym_stb = 1'b0; sym_code = '0;
    Reset = 1'b1;
    tick(); tick();

    // Frame A: len 5, two discarded zero symbols, overrun injected during FLUSH
    start_frame(5);
    send_sym(2'b00);
    send_sym(2'b00);
    check("a_sync_no_stb", 32'(n_stb), 32'd0);
    check("a_sync_active_low", 32'(dec_active), 32'd0);
    send_sym(2'b11);
    check("a_active_rises", 32'(dec_active), 32'd1);
    send_sym(2'b10);
    send_sym(2'b11);
    send_sym(2'b10);
    sym_stb = 1'b1; sym_code = 2'b10;
    tick();
    sym_stb = 1'b0;
    tick();
    sym_stb = 1'b1; sym_code = 2'b11;
    tick();
    sym_stb = 1'b0;
    check("a_overrun_set", 32'(overrun), 32'd1);
    wait_done("a_frame_done");
    check("a_stb_total", 32'(n_stb), 32'd45);
    check("a_data_codes", {stb_code[0][1:0], stb_code[1][1:0], stb_code[2][1:0],
                           stb_code[3][1:0], stb_code[4][1:0]}, 32'b11_10_11_10_10);
    check("a_zero_spacing_bad", 32'(zero_tail_bad(5)), 32'd0);
    check("a_stb12_flush", 32'(stb_state[11]), 32'd3);
    check("a_stb13_drain", 32'(stb_state[12]), 32'd4);
    check("a_bv_count", 32'(bv_idx.size()), 32'd5);
    check("a_bv_first_idx", 32'(bv_idx[0]), 32'd41);
    check("a_bv_last_idx", 32'(bv_idx[4]), 32'd45);
    check("a_bits", {bv_bit[0][0], bv_bit[1][0], bv_bit[2][0], bv_bit[3][0], bv_bit[4][0]},
          32'b10101);
    check("a_done_latency", 32'(fd_cyc - bv_cyc[4]), 32'd1);
    check("a_done_busy", 32'(fd_busy), 32'd0);
    check("a_done_active", 32'(fd_act), 32'd1);
    check("a_after_active", 32'(dec_active), 32'd0);
    check("a_after_busy", 32'(busy), 32'd0);
    check("a_overrun_sticky", 32'(overrun), 32'd1);

    // Frame B: reset after three RUN symbols
    start_frame(9);
    send_sym(2'b01);
    send_sym(2'b10);
    send_sym(2'b11);
    check("b_running", 32'(busy), 32'd1);
    Reset = 1'b0;
    tick();
    check("b_reset_outputs", 32'(all_out), 32'd0);
    Reset = 1'b1;
    repeat (6) tick();
    check("b_no_stb_after_reset", 32'(n_stb), 32'd0);
    check("b_no_done_after_reset", 32'(fd_cnt), 32'd0);

    // Frame C: len 2 after the abort
    start_frame(2);
    send_sym(2'b11);
    send_sym(2'b01);
    wait_done("c_frame_done");
    check("c_stb_total", 32'(n_stb), 32'd42);
    check("c_bv_count", 32'(bv_idx.size()), 32'd2);
    check("c_bits", {bv_bit[0][0], bv_bit[1][0]}, 32'b10);
    check("c_overrun_clear", 32'(overrun), 32'd0);

    // Frame D: len 0 behaves as len 1
    start_frame(0);
    send_sym(2'b10);
    wait_done("d_frame_done");
    check("d_data_code", 32'(stb_code[0]), 32'd2);
    check("d_first_in_flush", 32'(stb_state[0]), 32'd3);
    check("d_stb_total", 32'(n_stb), 32'd41);
    check("d_bv_count", 32'(bv_idx.size()), 32'd1);
    check("d_bit", 32'(bv_bit[0]), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
